// File: rtl/downwell_pkg.sv
// Shared screen geometry and motion FSM encoding for the player sprite logic.
// Latency: none (constants and types only).
// Backpressure: none (constants and types only).
package downwell_pkg;

   localparam int SCREEN_W = 160;
   localparam int SCREEN_H = 120;
   localparam int SPRITE_W = 4;
   localparam int SPRITE_H = 3;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_HMOVE = 2'd1,
      S_VMOVE = 2'd2,
      S_READY = 2'd3
   } motion_state_t;

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchronizer for a raw button, plus a one-cycle rising-edge pulse.
// Latency: level follows the pin after 2 clk; rise pulses 2 clk after a 0->1 change.
// Backpressure: none; the edge pulse is lost if the consumer does not take it.
module btn_sync (
   input  logic clk,
   input  logic reset,
   input  logic btn,
   output logic level,
   output logic rise
);

   logic meta;
   logic sync;
   logic sync_d;

   // Metastability filter followed by one delay stage for edge detection.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta   <= 1'b0;
         sync   <= 1'b0;
         sync_d <= 1'b0;
      end else begin
         meta   <= btn;
         sync   <= meta;
         sync_d <= sync;
      end
   end

   assign level = sync;
   assign rise  = sync & ~sync_d;

endmodule

// File: rtl/player_motion.sv
// Per-frame player position update (walk, jump, gravity, floor, walls, ceiling).
// Latency: pos_valid 3 clk after frame_tick; x_out/y_out update 1 clk after ld_next.
// Backpressure: pending coords wait in S_READY for ld_next; ticks outside S_IDLE are dropped and set sticky overrun.
module player_motion
   import downwell_pkg::*;
#(
   parameter logic [7:0] X_START  = 8'd76,
   parameter logic [6:0] Y_START  = 7'd4,
   parameter logic [7:0] X_MAX    = 8'(SCREEN_W - SPRITE_W),
   parameter logic [6:0] FLOOR_Y  = 7'(SCREEN_H - SPRITE_H),
   parameter logic [7:0] X_STEP   = 8'd1,
   parameter int         JUMP_V   = 4,
   parameter int         MAX_FALL = 3,
   parameter int         GRAV_DIV = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_left,
   input  logic       btn_right,
   input  logic       btn_jump,
   input  logic       frame_tick,
   input  logic       ld_next,
   output logic [7:0] x_out,
   output logic [6:0] y_out,
   output logic       pos_valid,
   output logic       grounded,
   output logic       overrun
);

   localparam logic signed [3:0] VY_JUMP   = 4'(0 - JUMP_V);
   localparam logic signed [3:0] VY_MAX    = 4'(MAX_FALL);
   localparam logic        [3:0] GCNT_LAST = 4'(GRAV_DIV - 1);
   localparam logic signed [8:0] FLOOR_S   = $signed({2'b00, FLOOR_Y});

   motion_state_t state_q, state_d;

   logic              left, right, jump_rise;
   logic              left_rise, right_rise;
   logic              unused_edges;
   logic              jump_req;
   logic [7:0]        x_p, x_h;
   logic [6:0]        y_p, y_n;
   logic signed [3:0] vy, vy_j, vy_n;
   logic [3:0]        gcnt, gcnt_n;
   logic              gr_j, gr_n;
   logic signed [8:0] ny;

   btn_sync u_sync_left  (.clk(clk), .reset(reset), .btn(btn_left),  .level(left),  .rise(left_rise));
   btn_sync u_sync_right (.clk(clk), .reset(reset), .btn(btn_right), .level(right), .rise(right_rise));
   btn_sync u_sync_jump  (.clk(clk), .reset(reset), .btn(btn_jump),  .level(),      .rise(jump_rise));

   // Walking only needs button levels; their edge pulses are deliberately unused.
   assign unused_edges = left_rise ^ right_rise;

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // Next state: one fixed pass per accepted frame, then wait for the draw controller.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (frame_tick) state_d = S_HMOVE;
         S_HMOVE: state_d = S_VMOVE;
         S_VMOVE: state_d = S_READY;
         S_READY: if (ld_next) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   assign pos_valid = (state_q == S_READY);

   // Horizontal step with wall saturation; opposing buttons cancel.
   always_comb begin
      x_h = x_p;
      if (right && !left)
         x_h = (x_p >= X_MAX - X_STEP) ? X_MAX : x_p + X_STEP;
      else if (left && !right)
         x_h = (x_p <= X_STEP) ? 8'd0 : x_p - X_STEP;
   end

   // Vertical update: jump launch, then position with floor/ceiling clamps, then gravity.
   always_comb begin
      vy_j = vy;
      gr_j = grounded;
      if (jump_req && grounded) begin
         vy_j = VY_JUMP;
         gr_j = 1'b0;
      end
      ny     = $signed({2'b00, y_p}) + $signed({{5{vy_j[3]}}, vy_j});
      y_n    = y_p;
      vy_n   = vy_j;
      gr_n   = gr_j;
      gcnt_n = gcnt;
      if (ny >= FLOOR_S) begin
         y_n    = FLOOR_Y;
         vy_n   = 4'sd0;
         gr_n   = 1'b1;
         gcnt_n = 4'd0;
      end else if (ny < 9'sd0) begin
         y_n  = 7'd0;
         vy_n = 4'sd0;
      end else begin
         y_n = ny[6:0];
      end
      if (!gr_n) begin
         if (gcnt_n == GCNT_LAST) begin
            gcnt_n = 4'd0;
            if (vy_n < VY_MAX) vy_n = vy_n + 4'sd1;
         end else begin
            gcnt_n = gcnt_n + 4'd1;
         end
      end
   end

   // A jump edge is remembered until the next vertical pass consumes it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) jump_req <= 1'b0;
      else       jump_req <= jump_rise | (jump_req & (state_q != S_VMOVE));
   end

   // Any tick the FSM cannot accept is remembered until reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                                  overrun <= 1'b0;
      else if (frame_tick && (state_q != S_IDLE)) overrun <= 1'b1;
   end

   // Pending motion state and committed coordinates.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         x_p      <= X_START;
         y_p      <= Y_START;
         vy       <= 4'sd0;
         gcnt     <= 4'd0;
         grounded <= 1'b0;
         x_out    <= X_START;
         y_out    <= Y_START;
      end else begin
         case (state_q)
            S_HMOVE: x_p <= x_h;
            S_VMOVE: begin
               y_p      <= y_n;
               vy       <= vy_n;
               gcnt     <= gcnt_n;
               grounded <= gr_n;
            end
            S_READY: if (ld_next) begin
               x_out <= x_p;
               y_out <= y_p;
            end
            default: ;
         endcase
      end
   end

endmodule
